// File: rtl/dot_pkg.sv
// rtl/dot_pkg.sv - shared sizes and types for the dot-matrix scan arbiter
package dot_pkg;

    localparam int ROWS = 10;
    localparam int COLS = 14;

    typedef enum logic {
        SRC_SCORE = 1'b0,
        SRC_ANIM  = 1'b1
    } src_t;

    typedef logic [COLS-1:0] row_t;

endpackage

// File: rtl/dot_row_scanner.sv
// rtl/dot_row_scanner.sv - row/slot counters, frame boundary strobe, one-hot row and blanked column drive
module dot_row_scanner #(
    parameter int  ROWS     = dot_pkg::ROWS,
    parameter int  COLS     = dot_pkg::COLS,
    parameter int  SCAN_DIV = 101,
    parameter int  BLANK    = 1,
    localparam int RW       = $clog2(ROWS),
    localparam int DW       = $clog2(SCAN_DIV)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] row_data,
    output logic [RW-1:0]   row_cnt,
    output logic            boundary,
    output logic            frame_start,
    output logic [ROWS-1:0] dot_10,
    output logic [COLS-1:0] dot_14
);

    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [RW-1:0]   row_cnt_q, row_cnt_d;
    logic [ROWS-1:0] dot_10_q, dot_10_d;
    logic [COLS-1:0] dot_14_q, dot_14_d;
    logic            frame_start_q, frame_start_d;
    logic            div_wrap;

    // Advance the slot/row counters and compute the next registered panel drive
    always_comb begin
        div_wrap      = (div_cnt_q == DW'(SCAN_DIV - 1));
        boundary      = div_wrap && (row_cnt_q == RW'(ROWS - 1));
        div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
        row_cnt_d     = row_cnt_q;
        if (div_wrap) begin
            row_cnt_d = (row_cnt_q == RW'(ROWS - 1)) ? '0 : row_cnt_q + 1'b1;
        end
        dot_10_d = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_cnt_q == RW'(i)) begin
                dot_10_d[ROWS-1-i] = 1'b1;
            end
        end
        dot_14_d      = (div_cnt_q < DW'(BLANK)) ? '0 : row_data;
        frame_start_d = boundary;
    end

    // Scanner state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q     <= '0;
            row_cnt_q     <= '0;
            dot_10_q      <= {1'b1, {(ROWS-1){1'b0}}};
            dot_14_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            row_cnt_q     <= row_cnt_d;
            dot_10_q      <= dot_10_d;
            dot_14_q      <= dot_14_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign row_cnt     = row_cnt_q;
    assign frame_start = frame_start_q;
    assign dot_10      = dot_10_q;
    assign dot_14      = dot_14_q;

endmodule

// File: rtl/dot_scan_arbiter.sv
// rtl/dot_scan_arbiter.sv - double-buffered dot-matrix scan with frame-boundary ownership arbitration
module dot_scan_arbiter #(
    parameter int ROWS     = dot_pkg::ROWS,
    parameter int COLS     = dot_pkg::COLS,
    parameter int SCAN_DIV = 101,
    parameter int BLANK    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req,
    output logic [1:0]      gnt,
    input  logic            wr_src,
    input  logic            wr_en,
    input  logic [3:0]      wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            commit,
    output logic            commit_pend,
    output logic            commit_done,
    output logic            frame_start,
    output logic [ROWS-1:0] dot_10,
    output logic [COLS-1:0] dot_14
);

    import dot_pkg::*;

    localparam int RW = $clog2(ROWS);

    logic [COLS-1:0] shadow_q [ROWS];
    logic [COLS-1:0] shadow_d [ROWS];
    logic [COLS-1:0] active_q [ROWS];
    logic [COLS-1:0] active_d [ROWS];
    logic [1:0]      gnt_q, gnt_d;
    src_t            last_q, last_d;
    logic            commit_pend_q, commit_pend_d;
    logic            commit_done_q, commit_done_d;

    logic [RW-1:0]   row_cnt;
    logic            boundary;
    logic [COLS-1:0] row_data;
    logic            src_owned;
    logic            wr_ok;
    logic            commit_ok;

    dot_row_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK    (BLANK)
    ) u_scanner (
        .clk         (clk),
        .rst_n       (rst_n),
        .row_data    (row_data),
        .row_cnt     (row_cnt),
        .boundary    (boundary),
        .frame_start (frame_start),
        .dot_10      (dot_10),
        .dot_14      (dot_14)
    );

    // Present the active-buffer row currently being scanned
    always_comb begin
        row_data = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (row_cnt == RW'(i)) begin
                row_data = active_q[i];
            end
        end
    end

    // Shadow writes, commit handshake, and swap plus arbitration on the frame boundary
    always_comb begin
        src_owned     = gnt_q[wr_src];
        wr_ok         = wr_en && src_owned && (wr_row < 4'(ROWS));
        commit_ok     = commit && src_owned && !commit_pend_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        commit_pend_d = commit_pend_q;
        commit_done_d = 1'b0;

        if (commit_ok) begin
            commit_pend_d = 1'b1;
        end

        if (boundary) begin
            // The copy uses the shadow as it stood before this cycle's write
            if (commit_pend_q) begin
                active_d      = shadow_q;
                commit_pend_d = 1'b0;
                commit_done_d = 1'b1;
            end
            case (req)
                2'b00: gnt_d = 2'b00;
                2'b01: begin
                    gnt_d  = 2'b01;
                    last_d = SRC_SCORE;
                end
                2'b10: begin
                    gnt_d  = 2'b10;
                    last_d = SRC_ANIM;
                end
                default: begin
                    if (last_q == SRC_ANIM) begin
                        gnt_d  = 2'b01;
                        last_d = SRC_SCORE;
                    end else begin
                        gnt_d  = 2'b10;
                        last_d = SRC_ANIM;
                    end
                end
            endcase
        end

        for (int i = 0; i < ROWS; i++) begin
            if (wr_ok && (wr_row == 4'(i))) begin
                shadow_d[i] = wr_data;
            end
        end
    end

    // Frame store, ownership and commit registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            gnt_q         <= 2'b00;
            last_q        <= SRC_ANIM;
            commit_pend_q <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            gnt_q         <= gnt_d;
            last_q        <= last_d;
            commit_pend_q <= commit_pend_d;
            commit_done_q <= commit_done_d;
        end
    end

    assign gnt         = gnt_q;
    assign commit_pend = commit_pend_q;
    assign commit_done = commit_done_q;

endmodule

// File: doc/dot_scan_arbiter.md
# dot_scan_arbiter

Row-scan controller and display arbiter for the 10×14 dot-matrix panel. It owns a double-buffered frame store, scans it onto the row/column drive lines at a fixed row rate, and shares the panel between two requesters: source 0 (score display) and source 1 (animation). Ownership and buffer swaps change only at frame boundaries, so the panel never tears. It sits between the game/animation logic and the panel pins, replacing per-mode hard-coded scan logic.

## Interface
- `ROWS`, 10, panel rows (row 0 drives `dot_10[ROWS-1]`).
- `COLS`, 14, panel columns.
- `SCAN_DIV`, 101, clk cycles per row slot (≥ BLANK+2).
- `BLANK`, 1, cycles at the start of each row slot with columns forced off.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  2  per-source ownership request, level.
- `gnt`  out  2  ownership grant, one-hot or zero.
- `wr_src`  in  1  source issuing the current `wr_en`/`commit`.
- `wr_en`  in  1  write `wr_data` into shadow row `wr_row`.
- `wr_row`  in  4  shadow row index.
- `wr_data`  in  COLS  row pattern; MSB = leftmost column.
- `commit`  in  1  pulse: swap shadow into active at next frame boundary.
- `commit_pend`  out  1  commit accepted, swap not yet done.
- `commit_done`  out  1  one-cycle pulse on the swap cycle.
- `frame_start`  out  1  one-cycle pulse when the scan wraps to row 0.
- `dot_10`  out  ROWS  one-hot row select.
- `dot_14`  out  COLS  column data for the selected row.

## Operation
- Scanner: `div_cnt` counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and `row_cnt` advances 0..ROWS-1, wrapping to 0. Boundary cycle = cycle where `div_cnt`=SCAN_DIV-1 and `row_cnt`=ROWS-1.
- Write/commit accepted only when `gnt[wr_src]`=1; otherwise ignored. `wr_row` ≥ ROWS ignored. `commit` while `commit_pend`=1 has no effect.
- Boundary cycle actions, in order: (1) if `commit_pend`, active ← shadow (pre-write shadow contents), `commit_pend`←0, `commit_done`=1; (2) arbitration; (3) a same-cycle shadow write lands after the copy.
- Arbitration (boundary only): no request → `gnt`=0. One requester → grant it. Both requesting → alternate: grant the source that did not own the previous frame (round-robin `last` pointer, reset to 1 so source 0 wins first). Owner keeps ownership if the other does not request. Owner dropping `req` mid-frame keeps `gnt` until the boundary.
- Ownership change clears `commit_pend` only if the pending commit was already applied (always true by ordering); shadow contents persist across owners.

## Timing
- Reset values: `div_cnt`=0, `row_cnt`=0, `dot_10`=1 at MSB (10'b1000000000), `dot_14`=0, both buffers 0, `gnt`=0, `commit_pend`=0, `commit_done`=0, `frame_start`=0, `last`=1.
- `dot_10`, `dot_14` registered: one cycle after `row_cnt`/`div_cnt` change. `dot_14`=0 when registered `div_cnt` < BLANK, else active[`row_cnt`].
- `frame_start`, `commit_done`, new `gnt` all assert the cycle after the boundary cycle (first cycle of row 0).
- `commit` → `commit_pend` high next cycle; swap latency ≤ ROWS·SCAN_DIV cycles.
- Reset mid-frame: all state returns to reset values the next edge; partial shadow writes discarded.

## Structure
- Package `dot_pkg`: `ROWS`, `COLS` defaults, `src_t` (SRC_SCORE=0, SRC_ANIM=1), row-pattern typedef `row_t` (COLS bits).
- Sub-module `dot_row_scanner`: `div_cnt`/`row_cnt`, boundary strobe, one-hot and blanking; parent holds buffers, arbiter, commit logic.

## Test plan (SCAN_DIV=4, BLANK=1)
- Reset, no requests → `dot_10` walks 10'b1000000000…10'b0000000001, 4 cycles each; `dot_14` always 0; `frame_start` every 40 cycles; `gnt`=0.
- `req`=2'b01 → `gnt`=2'b01 after next boundary; write row 2 = 14'b11111110000000, commit → row 2 slot shows 0 for 1 cycle then that pattern, from frame after `commit_done`.
- `req`=2'b11 held → `gnt` alternates 01,10,01 on successive `frame_start`.
- Source 1 writes/commits while `gnt`=2'b01 → shadow, active, `commit_pend` unchanged.
- Write row 0 = 14'h3FFF in the boundary cycle with commit pending → active row 0 gets old shadow; new value appears only after a second commit.
- `rst_n`=0 mid-row 5 with `commit_pend`=1 → next cycle all outputs at reset values, `dot_14`=0, `commit_pend`=0.
